// File: rtl/bubble_pkg.sv
// Shared encodings for the BUBBLE decode/issue slice: formats, opcodes and
// instruction field positions.
package bubble_pkg;

  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;

  localparam logic [1:0] FMT_R = 2'd0;
  localparam logic [1:0] FMT_I = 2'd1;
  localparam logic [1:0] FMT_J = 2'd2;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam int OP_MSB    = 31;
  localparam int OP_LSB    = 26;
  localparam int RS_MSB    = 25;
  localparam int RS_LSB    = 21;
  localparam int RT_MSB    = 20;
  localparam int RT_LSB    = 16;
  localparam int RD_MSB    = 15;
  localparam int RD_LSB    = 11;
  localparam int IMM_MSB   = 15;
  localparam int FUNCT_MSB = 5;
  localparam int TGT_MSB   = 25;

  localparam logic [4:0] LINK_REG = 5'd31;

endpackage

// File: rtl/bubble_regfile.sv
// Register file: two asynchronous read ports, one synchronous write port,
// r0 reads as zero and ignores writes.
module bubble_regfile
  import bubble_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [4:0]      waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [4:0]      raddr_a,
  input  logic [4:0]      raddr_b,
  output logic [XLEN-1:0] rdata_a,
  output logic [XLEN-1:0] rdata_b
);

  logic [XLEN-1:0] regs [NREG];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (we && (waddr != 5'd0)) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a = (raddr_a == 5'd0) ? '0 : regs[raddr_a];
  assign rdata_b = (raddr_b == 5'd0) ? '0 : regs[raddr_b];

endmodule

// File: rtl/decode_issue.sv
// Decode-and-issue stage: field split, scoreboard hazard stall, one registered
// issue packet. Optional writeback bypass is enabled by DECODE_WB_BYPASS_EN.
module decode_issue
  import bubble_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [31:0]     in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [1:0]      out_fmt,
  output logic [XLEN-1:0] out_rs,
  output logic [XLEN-1:0] out_rt,
  output logic [XLEN-1:0] out_imm,
  output logic [5:0]      out_funct,
  output logic [5:0]      out_alu_op,
  output logic [25:0]     out_target,
  output logic [4:0]      out_dest,
  output logic [31:0]     out_pc,
  input  logic            wb_en,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush
);

  // Handshake: a transfer happens on a rising edge where valid && ready are
  // both high; a held packet (out_valid && !out_ready) does not change.

  logic [5:0]      op;
  logic [4:0]      rs_a, rt_a, rd_a, dest;
  logic [1:0]      fmt;
  logic            use_rs, use_rt, fwd_rs, fwd_rt, hazard, accept;
  logic [XLEN-1:0] rf_rs, rf_rt, rs_val, rt_val;
  logic [NREG-1:0] busy, busy_set, busy_clr, busy_nxt;

  assign op   = in_instr[OP_MSB:OP_LSB];
  assign rs_a = in_instr[RS_MSB:RS_LSB];
  assign rt_a = in_instr[RT_MSB:RT_LSB];
  assign rd_a = in_instr[RD_MSB:RD_LSB];

  always_comb begin
    fmt    = FMT_I;
    dest   = rt_a;
    use_rs = 1'b1;
    use_rt = 1'b0;
    case (op)
      OP_RTYPE: begin fmt = FMT_R; dest = rd_a; use_rt = 1'b1; end
      OP_J:     begin fmt = FMT_J; dest = 5'd0; use_rs = 1'b0; end
      OP_JAL:   begin fmt = FMT_J; dest = LINK_REG; use_rs = 1'b0; end
      OP_BEQ, OP_BNE, OP_SW: begin dest = 5'd0; use_rt = 1'b1; end
      default: ;
    endcase
  end

  bubble_regfile #(.NREG(NREG), .XLEN(XLEN)) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .we      (wb_en),
    .waddr   (wb_addr),
    .wdata   (wb_data),
    .raddr_a (rs_a),
    .raddr_b (rt_a),
    .rdata_a (rf_rs),
    .rdata_b (rf_rt)
  );

`ifdef DECODE_WB_BYPASS_EN
  assign fwd_rs = wb_en && (wb_addr == rs_a) && (rs_a != 5'd0);
  assign fwd_rt = wb_en && (wb_addr == rt_a) && (rt_a != 5'd0);
`else
  assign fwd_rs = 1'b0;
  assign fwd_rt = 1'b0;
`endif

  assign rs_val = fwd_rs ? wb_data : rf_rs;
  assign rt_val = fwd_rt ? wb_data : rf_rt;

  // busy[0] is never set, so r0 sources and dest 0 never stall.
  assign hazard = (use_rs && busy[rs_a] && !fwd_rs) ||
                  (use_rt && busy[rt_a] && !fwd_rt) ||
                  busy[dest];

  assign in_ready = !hazard && !flush && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  // Set is applied after clear so an issue and a writeback to the same
  // register in one cycle leave it busy.
  always_comb begin
    busy_set = '0;
    busy_clr = '0;
    if (wb_en) busy_clr[wb_addr] = 1'b1;
    if (flush && out_valid) busy_clr[out_dest] = 1'b1;
    if (accept) busy_set[dest] = 1'b1;
    busy_nxt    = (busy & ~busy_clr) | busy_set;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy <= '0;
    else     busy <= busy_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_fmt    <= '0;
      out_rs     <= '0;
      out_rt     <= '0;
      out_imm    <= '0;
      out_funct  <= '0;
      out_alu_op <= '0;
      out_target <= '0;
      out_dest   <= '0;
      out_pc     <= '0;
    end else if (accept) begin
      out_valid  <= 1'b1;
      out_fmt    <= fmt;
      out_rs     <= rs_val;
      out_rt     <= rt_val;
      out_imm    <= {{(XLEN-16){in_instr[IMM_MSB]}}, in_instr[IMM_MSB:0]};
      out_funct  <= in_instr[FUNCT_MSB:0];
      out_alu_op <= op;
      out_target <= in_instr[TGT_MSB:0];
      out_dest   <= dest;
      out_pc     <= in_pc;
    end else if (flush || out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_issue.sv
// Bench for decode_issue: directed steps plus a packet scoreboard fed at
// acceptance and drained when the issue packet is consumed.
module tb_decode_issue;

  localparam int PW = 173;
  localparam int EW = PW + 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, wb_en, flush;
  logic [31:0] in_instr, in_pc, out_rs, out_rt, out_imm, out_pc, wb_data;
  logic [1:0]  out_fmt;
  logic [5:0]  out_funct, out_alu_op;
  logic [25:0] out_target;
  logic [4:0]  out_dest, wb_addr;

  int tests = 0;
  int fails = 0;
  logic [EW-1:0] exp_q[$];
  logic [31:0]   mdl_reg [32];
  logic          byp;

  decode_issue dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid),
    .out_ready(out_ready), .out_fmt(out_fmt), .out_rs(out_rs),
    .out_rt(out_rt), .out_imm(out_imm), .out_funct(out_funct),
    .out_alu_op(out_alu_op), .out_target(out_target), .out_dest(out_dest),
    .out_pc(out_pc), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .flush(flush)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc);
    in_valid = v;
    in_instr = instr;
    in_pc    = pc;
    #1;
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    wb_en = 1'b1; wb_addr = a; wb_data = d;
    tick();
    wb_en = 1'b0;
  endtask

  function automatic logic [31:0] mdl_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (byp && wb_en && wb_addr == a) return wb_data;
    return mdl_reg[a];
  endfunction

  // Expected entry: {use_rs, use_rt, fmt, rs, rt, imm, funct, op, target, dest, pc}
  function automatic logic [EW-1:0] mdl_pkt(input logic [31:0] i, input logic [31:0] pc);
    logic [5:0]  op;
    logic [1:0]  f;
    logic [4:0]  d;
    logic        urs, urt;
    logic [31:0] rs_v, rt_v;
    op = i[31:26];
    if (op == 6'h00) begin f = 2'd0; d = i[15:11]; urs = 1; urt = 1; end
    else if (op == 6'h02) begin f = 2'd2; d = 5'd0; urs = 0; urt = 0; end
    else if (op == 6'h03) begin f = 2'd2; d = 5'd31; urs = 0; urt = 0; end
    else if (op == 6'h04 || op == 6'h05 || op == 6'h2B) begin f = 2'd1; d = 5'd0; urs = 1; urt = 1; end
    else begin f = 2'd1; d = i[20:16]; urs = 1; urt = 0; end
    rs_v = urs ? mdl_read(i[25:21]) : 32'd0;
    rt_v = urt ? mdl_read(i[20:16]) : 32'd0;
    return {urs, urt, f, rs_v, rt_v, {{16{i[15]}}, i[15:0]}, i[5:0], op, i[25:0], d, pc};
  endfunction

  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (rst) begin
      exp_q.delete();
      for (int r = 0; r < 32; r++) mdl_reg[r] = 32'd0;
    end else begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_issue", {31'd0, out_valid}, 256'd0);
        end else if (flush) begin
          void'(exp_q.pop_front());
        end else begin
          e = exp_q[0];
          chk("packet", {out_fmt, e[EW-1] ? out_rs : 32'd0, e[EW-2] ? out_rt : 32'd0,
                         out_imm, out_funct, out_alu_op, out_target, out_dest, out_pc},
              e[PW-1:0]);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      if (in_valid && in_ready) exp_q.push_back(mdl_pkt(in_instr, in_pc));
      if (wb_en && wb_addr != 5'd0) mdl_reg[wb_addr] = wb_data;
    end
  end

  initial begin
`ifdef DECODE_WB_BYPASS_EN
    byp = 1'b1;
`else
    byp = 1'b0;
`endif
    rst = 1'b1; out_ready = 1'b1; flush = 1'b0;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    drive(1'b1, 32'h00221820, 32'h0);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_outputs", {out_fmt, out_rs, out_rt, out_imm, out_dest, out_pc}, 0);
    in_valid = 1'b0;
    tick(); tick();
    rst = 1'b0;
    wb(5'd1, 32'd10);
    wb(5'd2, 32'd20);

    // add r3,r1,r2
    drive(1'b1, 32'h00221820, 32'h100);
    chk("add_in_ready", in_ready, 1);
    tick(); in_valid = 1'b0;
    chk("add_valid", out_valid, 1);
    chk("add_fields", {out_fmt, out_rs, out_rt, out_funct, out_dest}, {2'd0, 32'd10, 32'd20, 6'h20, 5'd3});

    // addi r4,r1,-5
    drive(1'b1, 32'h2024FFFB, 32'h104);
    tick(); in_valid = 1'b0;
    chk("addi_fields", {out_fmt, out_imm, out_alu_op, out_dest}, {2'd1, 32'hFFFFFFFB, 6'h08, 5'd4});

    // jal 10, then j 10
    drive(1'b1, 32'h0C00000A, 32'h108);
    tick();
    chk("jal_fields", {out_fmt, out_target, out_dest}, {2'd2, 26'd10, 5'd31});
    drive(1'b1, 32'h0800000A, 32'h10C);
    tick(); in_valid = 1'b0;
    chk("j_fields", {out_fmt, out_dest}, {2'd2, 5'd0});

    // sub r5,r3,r1 waits on r3
    drive(1'b1, 32'h00612822, 32'h110);
    chk("raw_stall0", in_ready, 0);
    tick();
    chk("raw_stall1", in_ready, 0);
    wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'd30; #1;
    chk("wb_cycle_ready", in_ready, byp);
    tick(); wb_en = 1'b0;
    if (byp) begin
      in_valid = 1'b0;
      chk("sub_bypass", {out_valid, out_rs, out_dest}, {1'b1, 32'd30, 5'd5});
    end else begin
      #1;
      chk("sub_ready_after_wb", in_ready, 1);
      tick(); in_valid = 1'b0;
      chk("sub_late", {out_valid, out_rs, out_dest}, {1'b1, 32'd30, 5'd5});
    end
    tick();

    // WAW: addi r5 while r5 busy
    drive(1'b1, 32'h20050001, 32'h114);
    chk("waw_stall", in_ready, 0);
    in_valid = 1'b0;

    // backpressure
    out_ready = 1'b0;
    drive(1'b1, 32'h20060001, 32'h200);
    chk("bp_first_ready", in_ready, 1);
    tick();
    drive(1'b1, 32'h20090002, 32'h204);
    for (int k = 0; k < 3; k++) begin
      chk("bp_hold", {in_ready, out_valid, out_dest, out_pc}, {1'b0, 1'b1, 5'd6, 32'h200});
      tick();
    end
    out_ready = 1'b1; #1;
    chk("bp_release_ready", in_ready, 1);
    tick();
    chk("bp_next", out_dest, 5'd9);
    drive(1'b1, 32'h200A0003, 32'h208);
    tick(); in_valid = 1'b0;
    chk("bp_b2b", {out_valid, out_dest}, {1'b1, 5'd10});
    tick();

    // flush held packet dest r7
    out_ready = 1'b0;
    drive(1'b1, 32'h20070007, 32'h300);
    tick();
    chk("flush_held", {out_valid, out_dest}, {1'b1, 5'd7});
    flush = 1'b1;
    drive(1'b1, 32'h00E04020, 32'h304);
    chk("flush_blocks", in_ready, 0);
    tick();
    flush = 1'b0; out_ready = 1'b1; #1;
    chk("flush_valid", out_valid, 0);
    chk("flush_r7_free", in_ready, 1);
    tick(); in_valid = 1'b0;
    chk("after_flush", {out_valid, out_dest, out_rs}, {1'b1, 5'd8, 32'd0});

    // r0 write ignored; write to a non-busy register
    wb(5'd0, 32'd55);
    wb(5'd13, 32'd77);
    drive(1'b1, 32'h000D7020, 32'h400);
    tick(); in_valid = 1'b0;
    chk("r0_and_free_wb", {out_rs, out_rt, out_dest}, {32'd0, 32'd77, 5'd14});

    // issue and writeback to r15 in one cycle: r15 remains busy
    wb_en = 1'b1; wb_addr = 5'd15; wb_data = 32'd5;
    drive(1'b1, 32'h200F0001, 32'h404);
    tick(); wb_en = 1'b0;
    drive(1'b1, 32'h01E08020, 32'h408);
    chk("set_wins", in_ready, 0);
    in_valid = 1'b0;

    // reset mid-operation
    out_ready = 1'b0;
    drive(1'b1, 32'h20140001, 32'h500);
    tick(); in_valid = 1'b0;
    rst = 1'b1; #1;
    chk("midreset_valid", out_valid, 0);
    tick();
    rst = 1'b0; out_ready = 1'b1;
    drive(1'b1, 32'h003F2820, 32'h504);
    chk("post_reset_ready", in_ready, 1);
    tick(); in_valid = 1'b0;
    chk("post_reset_rf", {out_valid, out_rs, out_rt, out_dest}, {1'b1, 32'd0, 32'd0, 5'd5});
    tick(); tick();

    chk("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/decode_issue.md
# decode_issue

Decode-and-issue stage of the CSE BUBBLE processor, directly upstream of the ALU (`alu_r`, `alu_i`, `alu_j`). It accepts 32-bit instruction words from fetch over a valid/ready handshake, reads the register file, and splits each word into the fields the ALU consumes. It sign-extends immediates, tracks outstanding destination registers with a scoreboard, and presents one registered issue packet per cycle to the ALU.

## Interface
Parameters:
- `NREG`, 32: architectural register count; r0 is hardwired to zero.
- `XLEN`, 32: datapath width.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  fetch holds a valid instruction.
- `in_ready`  out  1  stage accepts the instruction this cycle.
- `in_instr`  in  32  instruction word.
- `in_pc`  in  32  PC of the instruction.
- `out_valid`  out  1  issue packet valid.
- `out_ready`  in  1  ALU consumes the packet.
- `out_fmt`  out  2  0=R, 1=I, 2=J.
- `out_rs`, `out_rt`  out  32 each  operand values.
- `out_imm`  out  32  sign-extended `instr[15:0]`.
- `out_funct`  out  6  `instr[5:0]`.
- `out_alu_op`  out  6  `instr[31:26]`.
- `out_target`  out  26  `instr[25:0]`.
- `out_dest`  out  5  destination register; 0 means none.
- `out_pc`  out  32  PC of the issued instruction.
- `wb_en`, `wb_addr[4:0]`, `wb_data[31:0]`  in  writeback port.
- `flush`  in  1  discard the held packet.

## Operation
- Format decode:
  - Opcode 0 is R-type.
  - Opcodes 2 and 3 are J-type.
  - All other opcodes are I-type.
- Destination:
  - R-type writes `rd`, `instr[15:11]`.
  - I-type writes `rt`, except opcodes 0x04, 0x05 and 0x2B, which have no destination.
  - Opcode 3 writes r31.
  - Opcode 2 has no destination.
- Sources:
  - R-type reads rs and rt.
  - I-type reads rs; opcodes 0x04, 0x05 and 0x2B also read rt.
  - J-type reads none.
- Reads of r0 return 0. Writes to r0 are ignored.
- Scoreboard: `NREG`-bit busy vector.
  - The bit for `out_dest` is set when an instruction is accepted and its dest is non-zero.
  - A bit is cleared when `wb_en` is high for that `wb_addr`.
  - If set and clear hit the same register in the same cycle, set wins.
- Hazard stall: `in_ready` drops if any used source register or the dest register is busy (RAW and WAW hazards).
- `in_ready = !hazard && (!out_valid || out_ready)`. Acceptance is `in_valid && in_ready`.
- The packet stays stable while `out_valid && !out_ready`.
- `flush`:
  - Clears `out_valid` next cycle.
  - Clears the busy bit of the held packet's dest.
  - Blocks acceptance in the flush cycle.
  - Writeback in the same cycle still applies.
- Reset:
  - `out_valid`=0, every other output=0, scoreboard=0, register file=0.
  - `in_ready` reads 1 during reset only if `in_valid` has no hazard, which always holds because the scoreboard is clear.

## Timing
- Latency is 1 cycle: an instruction accepted at edge N is presented at `out_*` after edge N.
- Throughput is 1 instruction per cycle with no hazard and `out_ready` held high.
- Register file writes take effect at the edge; the scoreboard clear takes effect at the same edge.
- Reset asserted mid-operation drops the in-flight packet and all busy bits immediately; no writeback is pending afterwards.
- A writeback to a register that is not busy still writes the register file.

## Configuration
- `DECODE_WB_BYPASS_EN` defined:
  - A same-cycle writeback to a source register forwards `wb_data` to the operand.
  - The same writeback removes that register from the hazard check.
  - The dependent instruction issues in the writeback cycle.
- `DECODE_WB_BYPASS_EN` undefined:
  - The hazard check uses only the registered busy vector.
  - The operand reads the pre-edge register file.
  - The dependent instruction accepts one cycle after the writeback.

## Structure
- `bubble_pkg` holds:
  - Format encoding constants `FMT_R`, `FMT_I`, `FMT_J`.
  - Opcode constants `OP_RTYPE`, `OP_J`, `OP_JAL`, `OP_BEQ`, `OP_BNE`, `OP_SW`.
  - Field bit positions, and `XLEN`/`NREG` defaults.
- Sub-module `bubble_regfile`: `NREG`x`XLEN` register file with 2 asynchronous read ports and 1 synchronous write port, r0 forced to 0. The bypass mux and scoreboard stay in `decode_issue`.

## Test plan
- Reset, then `add r3,r1,r2` (0x00221820) with r1=10, r2=20 preloaded via wb -> next cycle `out_fmt`=0, `out_rs`=10, `out_rt`=20, `out_funct`=0x20, `out_dest`=3.
- `addi r4,r1,-5` (0x2024FFFB) -> `out_fmt`=1, `out_imm`=0xFFFFFFFB, `out_alu_op`=0x08, `out_dest`=4.
- `jal` with target 10 -> `out_fmt`=2, `out_target`=10, `out_dest`=31; `j` -> `out_dest`=0.
- `add r3,...` followed by `sub r5,r3,r1` -> `in_ready`=0 until `wb_en`, `wb_addr`=3, `wb_data`=30:
  - with `DECODE_WB_BYPASS_EN`, the sub issues in the wb cycle with `out_rs`=30;
  - without it, the sub issues one cycle later.
- Hold `out_ready`=0 for 3 cycles with `in_valid`=1 -> packet stable, `in_ready`=0, nothing lost; release -> back-to-back issue.
- `flush` with held packet dest=7 -> `out_valid`=0 next cycle and r7 not busy; a following `add r8,r7,r0` accepts immediately.
